// File: rtl/sync_pkg.sv
// Shared types and helpers for the Gray-pointer synchronisers of the async FIFO family.
package sync_pkg;

  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;
  localparam int GRAY_W_MAX      = 32;

  typedef enum logic {
    WARMUP = 1'b0,
    RUN    = 1'b1
  } sync_state_e;

  // Prefix XOR from the MSB down; callers zero-extend narrower pointers, which is harmless.
  function automatic logic [GRAY_W_MAX-1:0] gray2bin(input logic [GRAY_W_MAX-1:0] g);
    logic [GRAY_W_MAX-1:0] b;
    b = g;
    b = b ^ (b >> 16);
    b = b ^ (b >> 8);
    b = b ^ (b >> 4);
    b = b ^ (b >> 2);
    b = b ^ (b >> 1);
    return b;
  endfunction

  function automatic logic popcount_gt1(input logic [GRAY_W_MAX-1:0] v);
    return (v & (v - GRAY_W_MAX'(1))) != '0;
  endfunction

endpackage

// File: rtl/sync_w2r_gray_rx_if.sv
// Read-side bundle of the write-to-read Gray pointer synchroniser.
interface sync_w2r_gray_rx_if #(
  parameter int ASIZE = 4
);
  logic [ASIZE:0] wptr_gray;
  logic           err_clr;
  logic [ASIZE:0] rq_gray;
  logic [ASIZE:0] rq_bin;
  logic [ASIZE:0] rq_delta;
  logic           rq_adv;
  logic           rq_valid;
  logic           gray_err;

  modport master (
    output wptr_gray, err_clr,
    input  rq_gray, rq_bin, rq_delta, rq_adv, rq_valid, gray_err
  );

  modport slave (
    input  wptr_gray, err_clr,
    output rq_gray, rq_bin, rq_delta, rq_adv, rq_valid, gray_err
  );
endinterface

// File: rtl/sync_chain.sv
// Plain multi-flop synchroniser; no logic between stages so each flop only sees a flop.
module sync_chain #(
  parameter int WIDTH  = 5,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_d [STAGES];
  logic [WIDTH-1:0] stage_q [STAGES];

  always_comb begin
    stage_d[0] = d;
    for (int i = 1; i < STAGES; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q <= stage_d;
    end
  end

  assign q = stage_q[STAGES-1];

endmodule

// File: rtl/sync_w2r_gray_rx.sv
// Write-to-read Gray pointer synchroniser with binary conversion, per-cycle advance,
// Gray-violation detection and a warm-up window that hides reset-flush artefacts.
module sync_w2r_gray_rx
  import sync_pkg::*;
#(
  parameter int ASIZE       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                rclk,
  input  logic                rrst,
  sync_w2r_gray_rx_if.slave   bus
);

  localparam int PW    = ASIZE + 1;
  localparam int CNT_W = 3;

  if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_stages
    $error("sync_w2r_gray_rx: SYNC_STAGES=%0d outside %0d..%0d",
           SYNC_STAGES, SYNC_STAGES_MIN, SYNC_STAGES_MAX);
  end

  logic [PW-1:0] rq_gray;

  sync_chain #(
    .WIDTH  (PW),
    .STAGES (SYNC_STAGES)
  ) u_chain (
    .clk (rclk),
    .rst (rrst),
    .d   (bus.wptr_gray),
    .q   (rq_gray)
  );

  sync_state_e    state_d, state_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic [PW-1:0]  bin_d, bin_q;
  logic [PW-1:0]  delta_d, delta_q;
  logic [PW-1:0]  prev_gray_d, prev_gray_q;
  logic           adv_d, adv_q;
  logic           err_d, err_q;
  logic           viol;

  always_comb begin
    bin_d       = PW'(gray2bin(GRAY_W_MAX'(rq_gray)));
    prev_gray_d = rq_gray;
    viol        = popcount_gt1(GRAY_W_MAX'(rq_gray ^ prev_gray_q));
    state_d     = state_q;
    cnt_d       = cnt_q;
    delta_d     = '0;
    adv_d       = 1'b0;
    err_d       = err_q;

    case (state_q)
      // The edge that leaves WARMUP still compares against reset-zero history, so it stays masked.
      WARMUP: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_d == CNT_W'(SYNC_STAGES + 1)) begin
          state_d = RUN;
        end
      end
      RUN: begin
        delta_d = bin_d - bin_q;
        adv_d   = (delta_d != '0);
        if (viol) begin
          err_d = 1'b1;
        end else if (bus.err_clr) begin
          err_d = 1'b0;
        end
      end
      default: state_d = WARMUP;
    endcase
  end

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      state_q     <= WARMUP;
      cnt_q       <= '0;
      bin_q       <= '0;
      delta_q     <= '0;
      prev_gray_q <= '0;
      adv_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bin_q       <= bin_d;
      delta_q     <= delta_d;
      prev_gray_q <= prev_gray_d;
      adv_q       <= adv_d;
      err_q       <= err_d;
    end
  end

  assign bus.rq_gray  = rq_gray;
  assign bus.rq_bin   = bin_q;
  assign bus.rq_delta = delta_q;
  assign bus.rq_adv   = adv_q;
  assign bus.rq_valid = (state_q == RUN);
  assign bus.gray_err = err_q;

endmodule

// File: tb/tb_sync_w2r_gray_rx.sv
// Directed bench: a 2-stage and a 3-stage instance share the same write pointer.
module tb_sync_w2r_gray_rx;

  localparam int ASIZE = 4;
  localparam int PW    = ASIZE + 1;

  logic          rclk = 1'b0;
  logic          rrst;
  logic [PW-1:0] wptr;
  logic          clr2;

  always #5 rclk = ~rclk;

  sync_w2r_gray_rx_if #(.ASIZE(ASIZE)) bus2 ();
  sync_w2r_gray_rx_if #(.ASIZE(ASIZE)) bus3 ();

  assign bus2.wptr_gray = wptr;
  assign bus3.wptr_gray = wptr;
  assign bus2.err_clr   = clr2;
  assign bus3.err_clr   = 1'b0;

  sync_w2r_gray_rx #(.ASIZE(ASIZE), .SYNC_STAGES(2)) u_dut2 (
    .rclk (rclk),
    .rrst (rrst),
    .bus  (bus2.slave)
  );

  sync_w2r_gray_rx #(.ASIZE(ASIZE), .SYNC_STAGES(3)) u_dut3 (
    .rclk (rclk),
    .rrst (rrst),
    .bus  (bus3.slave)
  );

  int checks = 0;
  int failures = 0;
  int cur;
  int adv2, adv3, wrap_delta;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [PW-1:0] g(input int b);
    logic [PW-1:0] bb;
    bb = PW'(b);
    return bb ^ (bb >> 1);
  endfunction

  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  task automatic sample_tick();
    tick();
    if (bus2.rq_adv) adv2++;
    if (bus3.rq_adv) adv3++;
    if (bus2.rq_adv && bus2.rq_bin == '0) wrap_delta = int'(bus2.rq_delta);
  endtask

  task automatic walk(input int steps, input int per);
    for (int i = 0; i < steps; i++) begin
      cur  = (cur + 1) % 32;
      wptr = g(cur);
      repeat (per) sample_tick();
    end
  endtask

  task automatic chk_all_zero(input string ph);
    chk_eq({ph, "_gray2"},  32'(bus2.rq_gray),  0);
    chk_eq({ph, "_bin2"},   32'(bus2.rq_bin),   0);
    chk_eq({ph, "_delta2"}, 32'(bus2.rq_delta), 0);
    chk_eq({ph, "_adv2"},   32'(bus2.rq_adv),   0);
    chk_eq({ph, "_valid2"}, 32'(bus2.rq_valid), 0);
    chk_eq({ph, "_err2"},   32'(bus2.gray_err), 0);
    chk_eq({ph, "_bin3"},   32'(bus3.rq_bin),   0);
    chk_eq({ph, "_valid3"}, 32'(bus3.rq_valid), 0);
    chk_eq({ph, "_err3"},   32'(bus3.gray_err), 0);
  endtask

  // Call right after rrst falls (1 ns past edge 0); wptr holds gray(2) = 5'b00011.
  task automatic warmup_seq(input string ph);
    for (int e = 1; e <= 6; e++) begin
      tick();
      chk_eq($sformatf("%s_valid2_e%0d", ph, e), 32'(bus2.rq_valid), (e >= 3) ? 1 : 0);
      chk_eq($sformatf("%s_bin2_e%0d", ph, e),   32'(bus2.rq_bin),   (e >= 3) ? 2 : 0);
      chk_eq($sformatf("%s_adv2_e%0d", ph, e),   32'(bus2.rq_adv),   0);
      chk_eq($sformatf("%s_err2_e%0d", ph, e),   32'(bus2.gray_err), 0);
      chk_eq($sformatf("%s_valid3_e%0d", ph, e), 32'(bus3.rq_valid), (e >= 4) ? 1 : 0);
      chk_eq($sformatf("%s_bin3_e%0d", ph, e),   32'(bus3.rq_bin),   (e >= 4) ? 2 : 0);
      if (e == 2) chk_eq($sformatf("%s_gray2_e2", ph), 32'(bus2.rq_gray), 3);
    end
  endtask

  initial begin
    rrst = 1'b1;
    wptr = 5'b00011;
    clr2 = 1'b0;
    cur  = 2;
    adv2 = 0;
    adv3 = 0;
    wrap_delta = 99;

    // Reset state and first warm-up
    repeat (2) tick();
    chk_all_zero("rst");
    rrst = 1'b0;
    warmup_seq("warm");

    // Legal walk 2 -> 7
    walk(5, 3);
    repeat (4) tick();
    chk_eq("walk_err2", 32'(bus2.gray_err), 0);
    chk_eq("walk_bin2", 32'(bus2.rq_bin), 7);
    chk_eq("walk_bin3", 32'(bus3.rq_bin), 7);

    // Latency: gray(7) -> gray(8) driven just after edge k
    cur  = 8;
    wptr = g(8);
    tick();
    chk_eq("lat_k1_gray2", 32'(bus2.rq_gray), 32'(g(7)));
    tick();
    chk_eq("lat_k2_gray2", 32'(bus2.rq_gray), 32'(g(8)));
    chk_eq("lat_k2_gray3", 32'(bus3.rq_gray), 32'(g(7)));
    tick();
    chk_eq("lat_k3_bin2",   32'(bus2.rq_bin),   8);
    chk_eq("lat_k3_delta2", 32'(bus2.rq_delta), 1);
    chk_eq("lat_k3_adv2",   32'(bus2.rq_adv),   1);
    chk_eq("lat_k3_gray3",  32'(bus3.rq_gray),  32'(g(8)));
    chk_eq("lat_k3_bin3",   32'(bus3.rq_bin),   7);
    tick();
    chk_eq("lat_k4_adv2",   32'(bus2.rq_adv),   0);
    chk_eq("lat_k4_delta2", 32'(bus2.rq_delta), 0);
    chk_eq("lat_k4_bin3",   32'(bus3.rq_bin),   8);
    chk_eq("lat_k4_delta3", 32'(bus3.rq_delta), 1);
    chk_eq("lat_k4_adv3",   32'(bus3.rq_adv),   1);
    tick();
    chk_eq("lat_k5_adv3",   32'(bus3.rq_adv),   0);

    // Full wrap: 32 single steps, 8 -> 31 -> 0 -> 8
    adv2 = 0;
    adv3 = 0;
    wrap_delta = 99;
    walk(32, 3);
    repeat (5) sample_tick();
    chk_eq("wrap_adv2_count", 32'(adv2), 32);
    chk_eq("wrap_adv3_count", 32'(adv3), 32);
    chk_eq("wrap_delta_31to0", 32'(wrap_delta), 1);
    chk_eq("wrap_err2", 32'(bus2.gray_err), 0);
    chk_eq("wrap_bin2", 32'(bus2.rq_bin), 8);

    // Violation: settle at gray 00000 then jump to 00011
    walk(24, 3);
    repeat (5) tick();
    chk_eq("pre_viol_bin2", 32'(bus2.rq_bin), 0);
    chk_eq("pre_viol_err2", 32'(bus2.gray_err), 0);
    wptr = 5'b00011;
    repeat (2) tick();
    chk_eq("viol_k2_gray2", 32'(bus2.rq_gray), 3);
    chk_eq("viol_k2_err2",  32'(bus2.gray_err), 0);
    tick();
    chk_eq("viol_k3_err2",   32'(bus2.gray_err), 1);
    chk_eq("viol_k3_bin2",   32'(bus2.rq_bin), 2);
    chk_eq("viol_k3_delta2", 32'(bus2.rq_delta), 2);
    repeat (4) tick();
    chk_eq("viol_hold_err2", 32'(bus2.gray_err), 1);
    chk_eq("viol_hold_err3", 32'(bus3.gray_err), 1);

    // Clear priority: err_clr coincides with a new violation, then clean
    wptr = 5'b00000;
    repeat (2) tick();
    clr2 = 1'b1;
    tick();
    chk_eq("clr_vs_viol_err2", 32'(bus2.gray_err), 1);
    tick();
    chk_eq("clr_clean_err2", 32'(bus2.gray_err), 0);
    clr2 = 1'b0;
    wptr = 5'b00011;
    repeat (5) tick();
    chk_eq("reviol_err2", 32'(bus2.gray_err), 1);

    // Asynchronous reset between edges while in RUN with errors set
    @(posedge rclk);
    #3;
    rrst = 1'b1;
    #1;
    chk_all_zero("async_rst");
    tick();
    rrst = 1'b0;
    warmup_seq("rewarm");

    // Stable input in RUN
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_eq($sformatf("stable_adv2_%0d", i),   32'(bus2.rq_adv),   0);
      chk_eq($sformatf("stable_delta2_%0d", i), 32'(bus2.rq_delta), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
